// File: rtl/mem_io_bridge.sv
// mem_io_bridge
//   Sits directly after the CPU memory port. Addresses below IO_BASE go to
//   block RAM. Addresses at or above IO_BASE select a small memory-mapped
//   I/O page: LEDs, synchronized switches, a prescaled timer and a TX byte
//   FIFO that drains to a serializer over valid/ready.
//   Read data comes back one cycle after the address for both spaces, which
//   matches the latency of the synchronous BRAM.
//
// Ports
//   clk, reset      system clock, synchronous active-high reset
//   memAddr         CPU address
//   memWrite        CPU store strobe
//   memWriteData    CPU store data
//   memDataInbound  read data to the CPU, one cycle after memAddr
//   ramAddr         BRAM address, passed through from memAddr
//   ramWe           BRAM write enable, asserted for RAM-space stores only
//   ramWriteData    BRAM write data, passed through from memWriteData
//   ramReadData     BRAM synchronous read data
//   switches        asynchronous board switches
//   leds            LED register
//   txData          byte at the head of the TX FIFO
//   txValid         TX FIFO is not empty
//   txReady         serializer takes txData this cycle
module mem_io_bridge #(
    parameter logic [15:0] IO_BASE        = 16'hFF00,
    parameter int          TIMER_PRESCALE = 50000,
    parameter int          TX_DEPTH       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] memAddr,
    input  logic        memWrite,
    input  logic [15:0] memWriteData,
    output logic [15:0] memDataInbound,
    output logic [15:0] ramAddr,
    output logic        ramWe,
    output logic [15:0] ramWriteData,
    input  logic [15:0] ramReadData,
    input  logic [15:0] switches,
    output logic [15:0] leds,
    output logic [7:0]  txData,
    output logic        txValid,
    input  logic        txReady
);

    localparam int PTR_W = $clog2(TX_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int PS_W  = (TIMER_PRESCALE > 1) ? $clog2(TIMER_PRESCALE) : 1;

    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(TIMER_PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TX_DEPTH);

    // Address decode
    logic        isIo;
    logic [15:0] ioOff;
    logic        selLed, selSw, selTimer, selTx;

    assign isIo     = (memAddr >= IO_BASE);
    assign ioOff    = memAddr - IO_BASE;
    assign selLed   = isIo && (ioOff == 16'd0);
    assign selSw    = isIo && (ioOff == 16'd1);
    assign selTimer = isIo && (ioOff == 16'd2);
    assign selTx    = isIo && (ioOff == 16'd3);

    assign ramAddr      = memAddr;
    assign ramWriteData = memWriteData;
    assign ramWe        = memWrite && !isIo;

    // LED register
    always_ff @(posedge clk) begin
        if (reset) begin
            leds <= '0;
        end else if (memWrite && selLed) begin
            leds <= memWriteData;
        end
    end

    // Two-flop switch synchronizer
    logic [15:0] swMeta, swSync;

    always_ff @(posedge clk) begin
        if (reset) begin
            swMeta <= '0;
            swSync <= '0;
        end else begin
            swMeta <= switches;
            swSync <= swMeta;
        end
    end

    // Timer: a CPU write restarts the prescaler and takes precedence over a tick
    logic [PS_W-1:0] prescaler;
    logic [15:0]     timerCount;

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler  <= '0;
            timerCount <= '0;
        end else if (memWrite && selTimer) begin
            prescaler  <= '0;
            timerCount <= memWriteData;
        end else if (prescaler == PS_LAST) begin
            prescaler  <= '0;
            timerCount <= timerCount + 16'd1;
        end else begin
            prescaler  <= prescaler + PS_W'(1);
        end
    end

    // TX FIFO
    logic [7:0]       txMem [TX_DEPTH];
    logic [PTR_W-1:0] rdPtr, wrPtr;
    logic [CNT_W-1:0] txCount;
    logic             ovf;
    logic             stsRdPend;
    logic             txFull, txEmpty;
    logic             push, pop, pushOk;
    logic [3:0]       txCount4;

    assign txFull   = (txCount == CNT_FULL);
    assign txEmpty  = (txCount == '0);
    assign txValid  = !txEmpty;
    assign txData   = txMem[rdPtr];
    assign push     = memWrite && selTx;
    assign pop      = txValid && txReady;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
    assign pushOk   = push && (!txFull || pop);
    assign txCount4 = 4'(txCount);

    always_ff @(posedge clk) begin
        if (pushOk) begin
            txMem[wrPtr] <= memWriteData[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdPtr     <= '0;
            wrPtr     <= '0;
            txCount   <= '0;
            ovf       <= 1'b0;
            stsRdPend <= 1'b0;
        end else begin
            if (pushOk) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            txCount <= txCount + CNT_W'(pushOk) - CNT_W'(pop);
            // A status read clears ovf one cycle later, so the read itself still
            // returns ovf=1; a dropped push in that later cycle sets it again.
            if (push && txFull && !pop) begin
                ovf <= 1'b1;
            end else if (stsRdPend) begin
                ovf <= 1'b0;
            end
            stsRdPend <= selTx && !memWrite;
        end
    end

    // I/O read mux; values are taken before any same-cycle write lands
    logic [15:0] ioSel;

    always_comb begin
        ioSel = '0;
        if (selLed) begin
            ioSel = leds;
        end else if (selSw) begin
            ioSel = swSync;
        end else if (selTimer) begin
            ioSel = timerCount;
        end else if (selTx) begin
            ioSel = {8'h00, txCount4, 1'b0, ovf, txEmpty, txFull};
        end
    end

    // Read-return stage, aligned with the BRAM's one-cycle read
    logic        rdIsIo;
    logic [15:0] ioRd;

    always_ff @(posedge clk) begin
        if (reset) begin
            rdIsIo <= 1'b1;
            ioRd   <= '0;
        end else begin
            rdIsIo <= isIo;
            ioRd   <= ioSel;
        end
    end

    assign memDataInbound = rdIsIo ? ioRd : ramReadData;

endmodule
